// File: rtl/mult_seq_ctrl.sv
// Multicycle sequencer for the 32-bit RISC-V multiplier (MUL/MULH/MULHSU/MULHU).
// Each operation is split into 16x16 partial products on one shared 17x17 signed MAC.
module mult_seq_ctrl #(
  parameter int unsigned ACC_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  output logic [31:0]      result_o,
  output logic [2:0]       step_o,
  output logic [ACC_W-1:0] acc_o
);

  if (ACC_W != 64) begin : g_acc_w_check
    $error("mult_seq_ctrl: ACC_W must be 64");
  end

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAlbl = 3'd1,
    StAlbh = 3'd2,
    StAhbl = 3'd3,
    StAhbh = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;

  state_e             r_state;
  state_e             w_state_next;
  logic [1:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [31:0]        r_result;

  logic               w_accept;
  logic               w_mac_en;
  logic               w_res_load;
  logic               w_sign_a;
  logic               w_sign_b;
  logic signed [16:0] w_al;
  logic signed [16:0] w_ah;
  logic signed [16:0] w_bl;
  logic signed [16:0] w_bh;
  logic signed [16:0] w_mul_a;
  logic signed [16:0] w_mul_b;
  logic [5:0]         w_sh;
  logic signed [33:0] w_pp;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_sign_a = (r_op == OpMulh) || (r_op == OpMulhsu);
  assign w_sign_b = (r_op == OpMulh);
  assign w_al     = {1'b0, r_a[15:0]};
  assign w_ah     = {w_sign_a & r_a[31], r_a[31:16]};
  assign w_bl     = {1'b0, r_b[15:0]};
  assign w_bh     = {w_sign_b & r_b[31], r_b[31:16]};

  always_comb begin
    w_mul_a = w_al;
    w_mul_b = w_bl;
    w_sh    = 6'd0;
    case (r_state)
      StAlbh: begin
        w_mul_b = w_bh;
        w_sh    = 6'd16;
      end
      StAhbl: begin
        w_mul_a = w_ah;
        w_sh    = 6'd16;
      end
      StAhbh: begin
        w_mul_a = w_ah;
        w_mul_b = w_bh;
        w_sh    = 6'd32;
      end
      default: ;
    endcase
  end

  assign w_pp       = w_mul_a * w_mul_b;
  assign w_addend   = {{(ACC_W-34){w_pp[33]}}, w_pp} << w_sh;
  assign w_acc_next = r_acc + w_addend;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mac_en     = 1'b0;
    w_res_load   = 1'b0;
    case (r_state)
      StIdle: begin
        if (valid_i && !kill_i) begin
          w_accept     = 1'b1;
          w_state_next = StAlbl;
        end
      end
      StAlbl: begin
        w_mac_en     = 1'b1;
        w_state_next = StAlbh;
      end
      StAlbh: begin
        w_mac_en     = 1'b1;
        w_state_next = StAhbl;
      end
      StAhbl: begin
        w_mac_en = 1'b1;
        if (r_op == OpMul) begin
          w_res_load   = 1'b1;
          w_state_next = StDone;
        end else begin
          w_state_next = StAhbh;
        end
      end
      StAhbh: begin
        w_mac_en     = 1'b1;
        w_res_load   = 1'b1;
        w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    // A flush abandons the operation without touching acc or result.
    if (kill_i && (r_state != StIdle)) begin
      w_state_next = StIdle;
      w_mac_en     = 1'b0;
      w_res_load   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_op     <= 2'b00;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= '0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op  <= op_i;
        r_a   <= op_a_i;
        r_b   <= op_b_i;
        r_acc <= '0;
      end else if (w_mac_en) begin
        r_acc <= w_acc_next;
      end
      if (w_res_load) begin
        r_result <= (r_op == OpMul) ? w_acc_next[31:0] : w_acc_next[63:32];
      end
    end
  end

  assign ready_o  = (r_state == StIdle);
  assign valid_o  = (r_state == StDone) && !kill_i;
  assign result_o = r_result;
  assign step_o   = r_state;
  assign acc_o    = r_acc;

endmodule
